u_idu: RTL and testbench
========================

# u_idu

Instruction decode stage of the in-order RV32I pipeline, directly downstream of the fetch unit. It consumes the fetch stage's valid/PC/instruction outputs and reads the register file. It decodes operands, immediate and control, and registers them into the ID/EX pipeline register. It also detects load-use hazards and raises a one-cycle stall request toward fetch.

## Interface
- NOP_INS, 32'h0000_0013: encoding reported on `idu_ins` for bubbles and reset.
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  kill ID/EX contents (taken branch / jump resolved in EX)
- stall  in  1  downstream hold; never includes `lu_stall`
- ifu_vld, ifu_pc, ifu_ins  in  1/32/32  fetch-stage outputs
- ex_ld  in  1  instruction currently in EX is a load
- ex_rd  in  5  destination of instruction in EX
- rf_ra1, rf_ra2  out  5  register file read addresses, combinational = `ifu_ins[19:15]`, `ifu_ins[24:20]`
- rf_rd1, rf_rd2  in  32  register file read data, combinational, write-first
- lu_stall  out  1  combinational load-use stall request; hazard logic ORs it into fetch's stall
- idu_vld, idu_pc, idu_ins  out  1/32/32  registered valid, PC, instruction
- idu_rs1_val, idu_rs2_val  out  32  registered operands
- idu_rs1, idu_rs2, idu_rd  out  5  registered register indices
- idu_imm  out  32  registered sign-extended immediate
- idu_alu_op  out  4  encodings: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- idu_funct3  out  3  registered `ins[14:12]`
- idu_src_imm, idu_src_pc  out  1  ALU operand B = imm; operand A = PC
- idu_we, idu_ld, idu_st, idu_br, idu_jal, idu_jalr, idu_ill, idu_mdu  out  1 each  registered control flags

## Operation
- Decode is combinational on `ifu_ins`, with opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (NOP), SYSTEM (NOP).
- Immediate formats:
  - I: `{20{i[31]}, i[31:20]}`
  - S: `{20{i[31]}, i[31:25], i[11:7]}`
  - B: `{19{i[31]}, i[31], i[7], i[30:25], i[11:8], 1'b0}`
  - U: `{i[31:12], 12'b0}`
  - J: `{11{i[31]}, i[31], i[19:12], i[20], i[30:21], 1'b0}`
  - All other formats: 0.
- ALU op mapping:
  - SUB/SRA are selected by `ins[30]` for OP. For OP-IMM only SRAI uses `ins[30]`.
  - LUI → PASSB with src_imm.
  - AUIPC/JAL → ADD with src_pc.
  - LOAD/STORE/JALR → ADD with src_imm.
  - BRANCH → SUB; comparison type is carried in funct3.
- `idu_we` is set for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP, and forced 0 when rd = x0.
- Unknown opcode, or OP with funct7 ∉ {0000000, 0100000}:
  - `idu_ill` = 1.
  - All of `idu_we`, `idu_ld`, `idu_st`, `idu_br`, `idu_jal`, `idu_jalr` = 0.
  - `idu_vld` stays 1 so a later stage can trap.
- Load-use:
  - `lu_stall` = `ifu_vld & ex_ld & ex_rd != 0 & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd))`.
  - uses_rs1 is true for all except LUI/AUIPC/JAL.
  - uses_rs2 is true for BRANCH/STORE/OP.
- Register update priority on each rising edge:
  1. flush: all outputs to reset values.
  2. stall: hold everything.
  3. lu_stall: insert bubble (`idu_vld` = 0, control flags 0, `idu_ins` = NOP_INS).
  4. Otherwise load decoded values; when `ifu_vld` = 0, load a bubble.
- Bubbles never assert `idu_we`, `idu_ld`, `idu_st`, `idu_br`, `idu_jal`, `idu_jalr` or `idu_ill`.

## Timing
- Reset: every registered output is 0, except `idu_ins` = NOP_INS. With `ifu_vld` = 0 after reset, `lu_stall` = 0.
- Latency: 1 cycle from the `ifu_*` sample edge to the `idu_*` outputs.
- Load-use penalty is exactly 1 cycle:
  - Fetch holds its outputs because it sees `lu_stall`.
  - The next cycle, the load has left EX, `ex_ld` drops, and the instruction issues.
- `flush` together with `stall` or `lu_stall`: flush wins.
- `stall` together with `lu_stall`: hold wins, with no bubble inserted.
- Reset asserted mid-operation: all registers return to reset values asynchronously. No state survives.

## Configuration
- `IDU_RV32M_EN` defined:
  - OP with funct7 = 0000001 decodes as MUL/DIV/REM.
  - Outputs `idu_mdu` = 1, `idu_we` = (rd != 0), `idu_alu_op` = {1'b0, funct3}, `idu_ill` = 0.
- `IDU_RV32M_EN` undefined:
  - `idu_mdu` is tied 0.
  - funct7 = 0000001 is illegal (`idu_ill` = 1).

## Test plan
- Reset release, `ifu_vld` = 0 → all `idu_*` = 0, `idu_ins` = 0x00000013, `lu_stall` = 0.
- `ifu_ins` = 0xFFF10093 (addi x1, x2, -1), `rf_rd1` = 5, pc = 0x40 → next cycle: `idu_vld` = 1, `idu_pc` = 0x40, `idu_imm` = 0xFFFFFFFF, `idu_rd` = 1, `idu_alu_op` = 0, `idu_src_imm` = 1, `idu_we` = 1, `idu_rs1_val` = 5.
- `ex_ld` = 1, `ex_rd` = 2, `ifu_ins` = add x3, x2, x4 → `lu_stall` = 1 the same cycle and a bubble the next cycle. With `ex_ld` = 0 the following cycle, the add issues with `idu_vld` = 1.
- `ifu_ins` = 0xFE000EE3 (beq x0, x0, -4) → `idu_br` = 1, `idu_imm` = 0xFFFFFFFC, `idu_alu_op` = 1.
- `flush` and `stall` asserted in the same cycle with valid contents → `idu_vld` = 0 and `idu_pc` = 0 next cycle. `stall` alone → all outputs unchanged for 3 cycles.
- `ifu_ins` = 0x02208033 (mul x0, x1, x2) → with the macro: `idu_mdu` = 1, `idu_we` = 0. Without the macro: `idu_ill` = 1, `idu_mdu` = 0.

Source files
------------

// File: rtl/u_idu_if.sv
// ID/EX pipeline bundle produced by the decode stage (u_idu drives master, EX consumes slave).
interface u_idu_if;
  logic        idu_vld;
  logic [31:0] idu_pc;
  logic [31:0] idu_ins;
  logic [31:0] idu_rs1_val;
  logic [31:0] idu_rs2_val;
  logic [4:0]  idu_rs1;
  logic [4:0]  idu_rs2;
  logic [4:0]  idu_rd;
  logic [31:0] idu_imm;
  logic [3:0]  idu_alu_op;
  logic [2:0]  idu_funct3;
  logic        idu_src_imm;
  logic        idu_src_pc;
  logic        idu_we;
  logic        idu_ld;
  logic        idu_st;
  logic        idu_br;
  logic        idu_jal;
  logic        idu_jalr;
  logic        idu_ill;
  logic        idu_mdu;

  modport master (
    output idu_vld, idu_pc, idu_ins, idu_rs1_val, idu_rs2_val,
           idu_rs1, idu_rs2, idu_rd, idu_imm, idu_alu_op, idu_funct3,
           idu_src_imm, idu_src_pc, idu_we, idu_ld, idu_st, idu_br,
           idu_jal, idu_jalr, idu_ill, idu_mdu
  );

  modport slave (
    input  idu_vld, idu_pc, idu_ins, idu_rs1_val, idu_rs2_val,
           idu_rs1, idu_rs2, idu_rd, idu_imm, idu_alu_op, idu_funct3,
           idu_src_imm, idu_src_pc, idu_we, idu_ld, idu_st, idu_br,
           idu_jal, idu_jalr, idu_ill, idu_mdu
  );
endinterface

// File: rtl/u_idu.sv
// RV32I decode stage: combinational decode, ID/EX register and load-use stall detection.
// Define IDU_RV32M_EN to decode OP funct7=0000001 as MUL/DIV/REM (flagged on idu_mdu).
module u_idu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        stall,
  input  logic        ifu_vld,
  input  logic [31:0] ifu_pc,
  input  logic [31:0] ifu_ins,
  input  logic        ex_ld,
  input  logic [4:0]  ex_rd,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        lu_stall,
  u_idu_if.master     idu
);

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        src_imm;
    logic        src_pc;
    logic        we;
    logic        ld;
    logic        st;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        ill;
    logic        mdu;
  } idex_t;

  // Reset, flush and bubbles all share this one register image.
  function automatic idex_t idex_bubble();
    idex_t b;
    b     = '0;
    b.ins = NOP_INS;
    return b;
  endfunction

  // alt_add picks SUB (OP only); alt_sh picks SRA for both OP and OP-IMM.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt_add,
                                         input logic alt_sh);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt_add ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt_sh ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opc;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        we_raw;
  logic        uses_rs1;
  logic        uses_rs2;
  idex_t       dec;
  idex_t       q;

  assign opc    = ifu_ins[6:0];
  assign funct7 = ifu_ins[31:25];
  assign rf_ra1 = ifu_ins[19:15];
  assign rf_ra2 = ifu_ins[24:20];

  assign imm_i = {{20{ifu_ins[31]}}, ifu_ins[31:20]};
  assign imm_s = {{20{ifu_ins[31]}}, ifu_ins[31:25], ifu_ins[11:7]};
  assign imm_b = {{19{ifu_ins[31]}}, ifu_ins[31], ifu_ins[7], ifu_ins[30:25],
                  ifu_ins[11:8], 1'b0};
  assign imm_u = {ifu_ins[31:12], 12'b0};
  assign imm_j = {{11{ifu_ins[31]}}, ifu_ins[31], ifu_ins[19:12], ifu_ins[20],
                  ifu_ins[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.vld     = 1'b1;
    dec.pc      = ifu_pc;
    dec.ins     = ifu_ins;
    dec.rs1_val = rf_rd1;
    dec.rs2_val = rf_rd2;
    dec.rs1     = ifu_ins[19:15];
    dec.rs2     = ifu_ins[24:20];
    dec.rd      = ifu_ins[11:7];
    dec.funct3  = ifu_ins[14:12];
    we_raw      = 1'b0;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;

    case (opc)
      OPC_LUI: begin
        dec.imm     = imm_u;
        dec.alu_op  = ALU_PASSB;
        dec.src_imm = 1'b1;
        we_raw      = 1'b1;
        uses_rs1    = 1'b0;
      end
      OPC_AUIPC: begin
        dec.imm     = imm_u;
        dec.alu_op  = ALU_ADD;
        dec.src_imm = 1'b1;
        dec.src_pc  = 1'b1;
        we_raw      = 1'b1;
        uses_rs1    = 1'b0;
      end
      OPC_JAL: begin
        dec.imm     = imm_j;
        dec.alu_op  = ALU_ADD;
        dec.src_imm = 1'b1;
        dec.src_pc  = 1'b1;
        dec.jal     = 1'b1;
        we_raw      = 1'b1;
        uses_rs1    = 1'b0;
      end
      OPC_JALR: begin
        dec.imm     = imm_i;
        dec.alu_op  = ALU_ADD;
        dec.src_imm = 1'b1;
        dec.jalr    = 1'b1;
        we_raw      = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.alu_op = ALU_SUB;
        dec.br     = 1'b1;
        uses_rs2   = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm     = imm_i;
        dec.alu_op  = ALU_ADD;
        dec.src_imm = 1'b1;
        dec.ld      = 1'b1;
        we_raw      = 1'b1;
      end
      OPC_STORE: begin
        dec.imm     = imm_s;
        dec.alu_op  = ALU_ADD;
        dec.src_imm = 1'b1;
        dec.st      = 1'b1;
        uses_rs2    = 1'b1;
      end
      OPC_OPIMM: begin
        // ins[30] is part of the immediate for ADDI, so only the shift group may use it.
        dec.imm     = imm_i;
        dec.alu_op  = alu_sel(ifu_ins[14:12], 1'b0, ifu_ins[30]);
        dec.src_imm = 1'b1;
        we_raw      = 1'b1;
      end
      OPC_OP: begin
        uses_rs2 = 1'b1;
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.alu_op = alu_sel(ifu_ins[14:12], ifu_ins[30], ifu_ins[30]);
          we_raw     = 1'b1;
        end
`ifdef IDU_RV32M_EN
        else if (funct7 == 7'b0000001) begin
          dec.alu_op = {1'b0, ifu_ins[14:12]};
          dec.mdu    = 1'b1;
          we_raw     = 1'b1;
        end
`endif
        else begin
          dec.ill = 1'b1;
        end
      end
      OPC_FENCE, OPC_SYSTEM: begin
      end
      default: begin
        dec.ill = 1'b1;
      end
    endcase

    dec.we = we_raw & (dec.rd != 5'd0);
  end

  assign lu_stall = ifu_vld & ex_ld & (ex_rd != 5'd0) &
                    ((uses_rs1 & (ifu_ins[19:15] == ex_rd)) |
                     (uses_rs2 & (ifu_ins[24:20] == ex_rd)));

  // Priority: flush > hold > load-use bubble > decoded/idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= idex_bubble();
    end else if (flush) begin
      q <= idex_bubble();
    end else if (!stall) begin
      if (lu_stall || !ifu_vld) q <= idex_bubble();
      else                      q <= dec;
    end
  end

  assign idu.idu_vld     = q.vld;
  assign idu.idu_pc      = q.pc;
  assign idu.idu_ins     = q.ins;
  assign idu.idu_rs1_val = q.rs1_val;
  assign idu.idu_rs2_val = q.rs2_val;
  assign idu.idu_rs1     = q.rs1;
  assign idu.idu_rs2     = q.rs2;
  assign idu.idu_rd      = q.rd;
  assign idu.idu_imm     = q.imm;
  assign idu.idu_alu_op  = q.alu_op;
  assign idu.idu_funct3  = q.funct3;
  assign idu.idu_src_imm = q.src_imm;
  assign idu.idu_src_pc  = q.src_pc;
  assign idu.idu_we      = q.we;
  assign idu.idu_ld      = q.ld;
  assign idu.idu_st      = q.st;
  assign idu.idu_br      = q.br;
  assign idu.idu_jal     = q.jal;
  assign idu.idu_jalr    = q.jalr;
  assign idu.idu_ill     = q.ill;
  assign idu.idu_mdu     = q.mdu;

endmodule

// File: tb/tb_u_idu.sv
// Scoreboard bench for u_idu: driver queues hand-computed ID/EX images, monitor checks each edge.
module tb_u_idu;
  logic        clk = 1'b0;
  logic        rstn, flush, stall, ifu_vld, ex_ld, lu_stall;
  logic [31:0] ifu_pc, ifu_ins, rf_rd1, rf_rd2;
  logic [4:0]  ex_rd, rf_ra1, rf_ra2;

  u_idu_if idu_bus();

  u_idu dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
    .ifu_vld(ifu_vld), .ifu_pc(ifu_pc), .ifu_ins(ifu_ins),
    .ex_ld(ex_ld), .ex_rd(ex_rd),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .lu_stall(lu_stall), .idu(idu_bus)
  );

  always #5 clk = ~clk;

  // fl = {src_imm, src_pc, we, ld, st, br, jal, jalr, ill, mdu}
  typedef struct {
    int          cyc;
    int          id;
    logic        vld;
    logic [31:0] pc, ins, rs1_val, rs2_val, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [9:0]  fl;
  } exp_t;

  typedef struct {
    logic [31:0] ins, imm;
    logic [3:0]  alu;
    logic [9:0]  fl;
  } vec_t;

  exp_t sbq[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s vec%0d: got %h want %h", nm, id, act, want);
    end
  endtask

  function automatic exp_t bub(input int id);
    exp_t b;
    b     = '{default: '0};
    b.id  = id;
    b.ins = 32'h0000_0013;
    return b;
  endfunction

  function automatic exp_t mk(input int id, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] imm, input logic [3:0] alu,
                              input logic [9:0] fl);
    exp_t e;
    e         = '{default: '0};
    e.id      = id;
    e.vld     = 1'b1;
    e.pc      = pc;
    e.ins     = ins;
    e.rs1_val = r1;
    e.rs2_val = r2;
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    e.rd      = ins[11:7];
    e.f3      = ins[14:12];
    e.imm     = imm;
    e.alu     = alu;
    e.fl      = fl;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a         = '{default: '0};
    a.vld     = idu_bus.idu_vld;
    a.pc      = idu_bus.idu_pc;
    a.ins     = idu_bus.idu_ins;
    a.rs1_val = idu_bus.idu_rs1_val;
    a.rs2_val = idu_bus.idu_rs2_val;
    a.rs1     = idu_bus.idu_rs1;
    a.rs2     = idu_bus.idu_rs2;
    a.rd      = idu_bus.idu_rd;
    a.imm     = idu_bus.idu_imm;
    a.alu     = idu_bus.idu_alu_op;
    a.f3      = idu_bus.idu_funct3;
    a.fl      = {idu_bus.idu_src_imm, idu_bus.idu_src_pc, idu_bus.idu_we, idu_bus.idu_ld,
                 idu_bus.idu_st, idu_bus.idu_br, idu_bus.idu_jal, idu_bus.idu_jalr,
                 idu_bus.idu_ill, idu_bus.idu_mdu};
    return a;
  endfunction

  task automatic cmp_rec(input exp_t a, input exp_t e);
    chk("vld",     e.id, 32'(a.vld),  32'(e.vld));
    chk("pc",      e.id, a.pc,        e.pc);
    chk("ins",     e.id, a.ins,       e.ins);
    chk("rs1_val", e.id, a.rs1_val,   e.rs1_val);
    chk("rs2_val", e.id, a.rs2_val,   e.rs2_val);
    chk("rs1",     e.id, 32'(a.rs1),  32'(e.rs1));
    chk("rs2",     e.id, 32'(a.rs2),  32'(e.rs2));
    chk("rd",      e.id, 32'(a.rd),   32'(e.rd));
    chk("imm",     e.id, a.imm,       e.imm);
    chk("alu_op",  e.id, 32'(a.alu),  32'(e.alu));
    chk("funct3",  e.id, 32'(a.f3),   32'(e.f3));
    chk("flags",   e.id, 32'(a.fl),   32'(e.fl));
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic ld, input logic [4:0] rd);
    ifu_vld = v;
    ifu_pc  = pc;
    ifu_ins = ins;
    rf_rd1  = r1;
    rf_rd2  = r2;
    ex_ld   = ld;
    ex_rd   = rd;
    #1;
  endtask

  task automatic step(input exp_t e);
    e.cyc = cyc + 1;
    sbq.push_back(e);
    last = e;
    @(negedge clk);
  endtask

  // Monitor: one ID/EX image is due after every posedge that the driver queued for.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL sb_late vec%0d: due cycle %0d seen %0d", e.id, e.cyc, cyc);
        end else begin
          cmp_rec(sample(), e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ADD_X3 = 32'h0041_01B3;
  localparam logic [31:0] ADDI_X1 = 32'hFFF1_0093;
  localparam logic [31:0] LUI_X5 = 32'h1234_52B7;
  localparam logic [31:0] BEQ = 32'hFE00_0EE3;
  localparam logic [31:0] MUL_X0 = 32'h0220_8033;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{32'h0043_A303, 32'h0000_0004, 4'd0, 10'b1011000000}; // lw x6,4(x7)
    tbl[1]  = '{32'hFE51_2C23, 32'hFFFF_FFF8, 4'd0, 10'b1000100000}; // sw x5,-8(x2)
    tbl[2]  = '{32'h0080_00EF, 32'h0000_0008, 4'd0, 10'b1110001000}; // jal x1,8
    tbl[3]  = '{32'h4033_5293, 32'h0000_0403, 4'd7, 10'b1010000000}; // srai x5,x6,3
    tbl[4]  = '{32'h4031_00B3, 32'h0000_0000, 4'd1, 10'b0010000000}; // sub x1,x2,x3
    tbl[5]  = '{32'h0050_8013, 32'h0000_0005, 4'd0, 10'b1000000000}; // addi x0,x1,5
    tbl[6]  = '{32'hFFFF_FFFF, 32'h0000_0000, 4'd0, 10'b0000000010}; // unknown opcode
    tbl[7]  = '{32'h0000_1217, 32'h0000_1000, 4'd0, 10'b1110000000}; // auipc x4,1
    tbl[8]  = '{32'h0002_80E7, 32'h0000_0000, 4'd0, 10'b1010000100}; // jalr x1,0(x5)
    tbl[9]  = '{32'h0094_63B3, 32'h0000_0000, 4'd8, 10'b0010000000}; // or x7,x8,x9
    tbl[10] = '{32'h0000_000F, 32'h0000_0000, 4'd0, 10'b0000000000}; // fence

    rstn  = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    drv(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset state; idle fetch must not raise lu_stall even with a matching EX load.
    drv(1'b0, 32'h0, ADDI_X1, 32'h0, 32'h0, 1'b1, 5'd2);
    cmp_rec(sample(), bub(0));
    chk("lu_idle", 0, 32'(lu_stall), 32'd0);
    step(bub(1));

    drv(1'b1, 32'h40, ADDI_X1, 32'd5, 32'd0, 1'b0, 5'd0);
    chk("rf_ra1", 2, 32'(rf_ra1), 32'd2);
    chk("rf_ra2", 2, 32'(rf_ra2), 32'd31);
    chk("lu_none", 2, 32'(lu_stall), 32'd0);
    step(mk(2, 32'h40, ADDI_X1, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'd0, 10'b1010000000));

    // Load-use on rs1: bubble, then the add issues once the load has left EX.
    drv(1'b1, 32'h44, ADD_X3, 32'h11, 32'h22, 1'b1, 5'd2);
    chk("lu_rs1", 3, 32'(lu_stall), 32'd1);
    step(bub(3));
    drv(1'b1, 32'h44, ADD_X3, 32'h11, 32'h22, 1'b0, 5'd0);
    chk("lu_clr", 4, 32'(lu_stall), 32'd0);
    step(mk(4, 32'h44, ADD_X3, 32'h11, 32'h22, 32'h0, 4'd0, 10'b0010000000));

    drv(1'b1, 32'h48, ADD_X3, 32'h11, 32'h22, 1'b1, 5'd4);
    chk("lu_rs2", 5, 32'(lu_stall), 32'd1);
    step(bub(5));

    // LUI reads no rs1, so a matching EX load must not stall it.
    drv(1'b1, 32'h4C, LUI_X5, 32'h33, 32'h44, 1'b1, 5'd8);
    chk("lu_lui", 6, 32'(lu_stall), 32'd0);
    step(mk(6, 32'h4C, LUI_X5, 32'h33, 32'h44, 32'h1234_5000, 4'd10, 10'b1010000000));

    // Load into x0 never stalls.
    drv(1'b1, 32'h50, BEQ, 32'h0, 32'h0, 1'b1, 5'd0);
    chk("lu_x0", 7, 32'(lu_stall), 32'd0);
    step(mk(7, 32'h50, BEQ, 32'h0, 32'h0, 32'hFFFF_FFFC, 4'd1, 10'b0000010000));

    for (int i = 0; i < 11; i++) begin
      drv(1'b1, 32'h100 + 32'(4 * i), tbl[i].ins, 32'h1000 + 32'(i), 32'h2000 + 32'(i),
          1'b0, 5'd0);
      step(mk(10 + i, 32'h100 + 32'(4 * i), tbl[i].ins, 32'h1000 + 32'(i),
              32'h2000 + 32'(i), tbl[i].imm, tbl[i].alu, tbl[i].fl));
    end

    drv(1'b1, 32'h200, MUL_X0, 32'h7, 32'h9, 1'b0, 5'd0);
`ifdef IDU_RV32M_EN
    step(mk(30, 32'h200, MUL_X0, 32'h7, 32'h9, 32'h0, 4'd0, 10'b0000000001));
`else
    step(mk(30, 32'h200, MUL_X0, 32'h7, 32'h9, 32'h0, 4'd0, 10'b0000000010));
`endif

    // Hold for 3 cycles; the middle cycle also carries a load-use hazard (hold wins).
    drv(1'b1, 32'h204, ADDI_X1, 32'd5, 32'd0, 1'b0, 5'd0);
    step(mk(31, 32'h204, ADDI_X1, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'd0, 10'b1010000000));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_t h;
      drv(1'b1, 32'h300 + 32'(4 * i), ADD_X3, 32'hAA, 32'hBB, (i == 1), 5'd2);
      h    = last;
      h.id = 32 + i;
      step(h);
    end

    // Flush together with stall wins.
    flush = 1'b1;
    drv(1'b1, 32'h400, ADD_X3, 32'hAA, 32'hBB, 1'b0, 5'd0);
    step(bub(35));
    flush = 1'b0;
    stall = 1'b0;

    drv(1'b1, 32'h404, LUI_X5, 32'h1, 32'h2, 1'b0, 5'd0);
    step(mk(36, 32'h404, LUI_X5, 32'h1, 32'h2, 32'h1234_5000, 4'd10, 10'b1010000000));
    flush = 1'b1;
    drv(1'b1, 32'h408, ADD_X3, 32'h1, 32'h2, 1'b1, 5'd3);
    step(bub(37));
    flush = 1'b0;

    // Asynchronous reset in the middle of valid traffic.
    drv(1'b1, 32'h40C, BEQ, 32'h0, 32'h0, 1'b0, 5'd0);
    step(mk(38, 32'h40C, BEQ, 32'h0, 32'h0, 32'hFFFF_FFFC, 4'd1, 10'b0000010000));
    rstn = 1'b0;
    #1;
    cmp_rec(sample(), bub(39));
    @(negedge clk);
    rstn = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    step(bub(40));
    @(negedge clk);

    chk("sb_empty", 41, 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
